mul_iter_unit: RTL and testbench

- Multi-cycle iterative shift-add multiplier for the ARM datapath's multiply class: MUL, MLA, UMULL, UMLAL, SMULL, SMLAL.
- Sits directly upstream of the condition-flags generator.
  - Drives result_lo/result_hi, which feed the flags stage's multiply inputs.
  - Drives done, which qualifies the flag update.
- Replaces a single-cycle 32x32 array; the core stalls on busy.

---
 rtl/mul_pkg.sv | 37 +++
 rtl/mul_step.sv | 30 +++
 rtl/mul_iter_unit.sv | 165 ++++++++++++++++
 tb/tb_mul_iter_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared types and opcode helpers for the iterative multiplier.
//   mul_op_t    : ARM multiply-class operation select (3 bits; 2 and 3 are
//                 reserved and decode as plain MUL)
//   mul_state_t : sequencer states
//   is_long / is_signed / is_acc : opcode property decode
package mul_pkg;

  typedef enum logic [2:0] {
    MUL   = 3'd0,
    MLA   = 3'd1,
    UMULL = 3'd4,
    UMLAL = 3'd5,
    SMULL = 3'd6,
    SMLAL = 3'd7
  } mul_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } mul_state_t;

  // Reserved encodings have op[2]=0 and are not MLA, so all three
  // helpers report them as a plain MUL.
  function automatic logic is_long(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_signed(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_acc(input logic [2:0] op);
    return (op == MLA) || (op == UMLAL) || (op == SMLAL);
  endfunction

endpackage

// File: rtl/mul_step.sv
// mul_step: one combinational shift-add step of the iterative multiplier.
//   i_pp     : running partial product (2*WIDTH)
//   i_mcand  : multiplicand (WIDTH)
//   i_slice  : low STEP_BITS of the remaining multiplier
//   i_pos    : bit position of this slice within the original multiplier
//   o_pp     : i_pp + (i_slice * i_mcand) << i_pos
module mul_step #(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 2,
  parameter int POSW      = 6
) (
  input  logic [2*WIDTH-1:0] i_pp,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [STEP_BITS-1:0] i_slice,
  input  logic [POSW-1:0]    i_pos,
  output logic [2*WIDTH-1:0] o_pp
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] w_mcand_ext;
  logic [PW-1:0] w_slice_ext;
  logic [PW-1:0] w_term;

  assign w_mcand_ext = {{WIDTH{1'b0}}, i_mcand};
  assign w_slice_ext = {{(PW-STEP_BITS){1'b0}}, i_slice};
  assign w_term      = (w_mcand_ext * w_slice_ext) << i_pos;
  assign o_pp        = i_pp + w_term;

endmodule

// File: rtl/mul_iter_unit.sv
// mul_iter_unit: multi-cycle shift-add multiplier for MUL/MLA/UMULL/UMLAL/
// SMULL/SMLAL. Signed forms multiply magnitudes and negate in FIX.
//   clk, reset_n          : clock, async active-low reset
//   start, flush          : begin (IDLE only) / abort operation
//   op                    : mul_op_t select
//   rn, rs                : multiplicand, multiplier
//   acc_lo, acc_hi        : accumulate words
//   busy, done            : in-progress level, one-cycle completion pulse
//   result_lo, result_hi  : held result (hi forced 0 for MUL/MLA)
// Optional build macro MUL_EARLY_TERMINATE_EN: leave CALC as soon as the
// remaining multiplier is zero.
module mul_iter_unit
  import mul_pkg::*;
#(
  parameter int STEP_BITS = 2,
  parameter int WIDTH     = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             flush,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rn,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  localparam int PW    = 2 * WIDTH;
  localparam int NSTEP = WIDTH / STEP_BITS;
  localparam int CW    = $clog2(NSTEP + 1);
  localparam int POSW  = $clog2(WIDTH) + 1;

  mul_state_t       r_state;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic             r_sign;
  logic [CW-1:0]    r_cnt;
  logic [POSW-1:0]  r_pos;
  logic [PW-1:0]    r_product;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_res_lo;
  logic [WIDTH-1:0] r_res_hi;

  logic [WIDTH-1:0] w_rn_mag;
  logic [WIDTH-1:0] w_rs_mag;
  logic [PW-1:0]    w_pp_next;
  logic [WIDTH-1:0] w_mplier_next;
  logic             w_last;
  logic [PW-1:0]    w_prod_signed;
  logic [PW-1:0]    w_acc;
  logic [PW-1:0]    w_sum;

  assign w_rn_mag = (is_signed(op) && rn[WIDTH-1]) ? -rn : rn;
  assign w_rs_mag = (is_signed(op) && rs[WIDTH-1]) ? -rs : rs;

  mul_step #(
    .WIDTH    (WIDTH),
    .STEP_BITS(STEP_BITS),
    .POSW     (POSW)
  ) u_step (
    .i_pp   (r_product),
    .i_mcand(r_mcand),
    .i_slice(r_mplier[STEP_BITS-1:0]),
    .i_pos  (r_pos),
    .o_pp   (w_pp_next)
  );

  assign w_mplier_next = r_mplier >> STEP_BITS;

`ifdef MUL_EARLY_TERMINATE_EN
  // Remaining slices are all zero, so further steps would add nothing.
  assign w_last = (r_cnt == CW'(1)) || (w_mplier_next == '0);
`else
  assign w_last = (r_cnt == CW'(1));
`endif

  assign w_prod_signed = r_sign ? -r_product : r_product;

  always_comb begin
    w_acc = '0;
    if (is_acc(r_op)) begin
      w_acc = is_long(r_op) ? {r_acc_hi, r_acc_lo} : {{WIDTH{1'b0}}, r_acc_lo};
    end
  end

  assign w_sum = w_prod_signed + w_acc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_acc_lo  <= '0;
      r_acc_hi  <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_sign    <= 1'b0;
      r_cnt     <= '0;
      r_pos     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_res_lo  <= '0;
      r_res_hi  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !flush) begin
            r_op      <= op;
            r_acc_lo  <= acc_lo;
            r_acc_hi  <= acc_hi;
            r_mcand   <= w_rn_mag;
            r_mplier  <= w_rs_mag;
            r_sign    <= is_signed(op) & (rn[WIDTH-1] ^ rs[WIDTH-1]);
            r_cnt     <= CW'(NSTEP);
            r_pos     <= '0;
            r_product <= '0;
            r_busy    <= 1'b1;
            r_state   <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_product <= w_pp_next;
            r_mplier  <= w_mplier_next;
            r_pos     <= r_pos + POSW'(STEP_BITS);
            r_cnt     <= r_cnt - CW'(1);
            if (w_last) r_state <= FIX;
          end
        end
        FIX: begin
          if (!flush) begin
            r_res_lo <= w_sum[WIDTH-1:0];
            r_res_hi <= is_long(r_op) ? w_sum[PW-1:WIDTH] : '0;
            r_done   <= 1'b1;
          end
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign result_lo = r_res_lo;
  assign result_hi = r_res_hi;

endmodule

// File: tb/tb_mul_iter_unit.sv
module tb_mul_iter_unit;
  import mul_pkg::*;

  localparam int W     = 32;
  localparam int SB    = 2;
  localparam int NSTEP = W / SB;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rn = '0, rs = '0, acc_lo = '0, acc_hi = '0;
  logic        busy, done;
  logic [31:0] result_lo, result_hi;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_lo = '0, m_hi = '0;

  mul_iter_unit #(.STEP_BITS(SB), .WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .flush(flush), .op(op),
    .rn(rn), .rs(rs), .acc_lo(acc_lo), .acc_hi(acc_hi),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a, b, alo, ahi);
    logic [63:0] p;
    longint sp;
    if (o == SMULL || o == SMLAL) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      p  = 64'(sp);
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    if (o == MLA) p = p + {32'b0, alo};
    if (o == UMLAL || o == SMLAL) p = p + {ahi, alo};
    if (o == UMULL || o == UMLAL || o == SMULL || o == SMLAL) return p;
    return {32'b0, p[31:0]};
  endfunction

  function automatic int ref_latency(input logic [2:0] o, input logic [31:0] b);
`ifdef MUL_EARLY_TERMINATE_EN
    logic [31:0] m;
    int steps;
    m = ((o == SMULL || o == SMLAL) && b[31]) ? -b : b;
    steps = 1;
    while (steps < NSTEP && (m >> (SB * steps)) != 0) steps++;
    return steps + 1;
`else
    return NSTEP + 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, b, alo, ahi, input string tag);
    logic [63:0] e;
    int el, k, busy_n;
    e  = ref_result(o, a, b, alo, ahi);
    el = ref_latency(o, b);
    @(negedge clk);
    op = o; rn = a; rs = b; acc_lo = alo; acc_hi = ahi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rn = $urandom; rs = $urandom; acc_lo = $urandom; acc_hi = $urandom; op = 3'($urandom);
    k = 0; busy_n = 0;
    while (!done && k < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      k++;
    end
    check({tag, " latency"}, 64'(k), 64'(el));
    check({tag, " busy_cycles"}, 64'(busy_n), 64'(el));
    check({tag, " busy_with_done"}, {63'b0, busy}, 64'b0);
    check({tag, " result"}, {result_hi, result_lo}, e);
    m_lo = e[31:0]; m_hi = e[63:32];
    @(negedge clk);
    check({tag, " done_pulse"}, {63'b0, done}, 64'b0);
  endtask

  initial begin
    int k, fk, el, ndone;
    logic [2:0] ro;
    logic [31:0] ra, rb;

    #1;
    check("reset_outputs", {busy, done, result_hi, result_lo}, 66'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    do_op(SMULL, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, "smull_neg2x3");
    do_op(UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, "umull_max");
    do_op(MLA, 32'd7, 32'd6, 32'd5, 32'hDEAD_BEEF, "mla_7x6p5");
    do_op(UMLAL, 32'd1, 32'd1, 32'hFFFFFFFF, 32'd1, "umlal_carry");
    do_op(UMULL, 32'h12345678, 32'd1, 32'h0, 32'h0, "umull_x1");
    do_op(UMULL, 32'h12345678, 32'd0, 32'h0, 32'h0, "umull_x0");
    do_op(SMLAL, 32'h80000000, 32'h80000000, 32'h5, 32'hFFFFFFFF, "smlal_minmin");
    do_op(3'd2, 32'd9, 32'd9, 32'd100, 32'd100, "reserved_as_mul");

    // Flush a MUL 3*5 partway through.
    el = ref_latency(MUL, 32'd5);
    fk = (el - 1 < 8) ? el - 1 : 8;
    @(negedge clk);
    op = MUL; rn = 32'd3; rs = 32'd5; acc_lo = 0; acc_hi = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < fk; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'b0);
    check("flush_results", {result_hi, result_lo}, {m_hi, m_lo});
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("flush_no_done", 64'(ndone), 64'd0);

    // Start while busy is ignored.
    @(negedge clk);
    op = UMULL; rn = 32'h9ABCDEF0; rs = 32'h87654321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    op = UMULL; rn = 32'd2; rs = 32'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 45; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("busy_start_one_done", 64'(ndone), 64'd1);
    check("busy_start_result", {result_hi, result_lo},
          ref_result(UMULL, 32'h9ABCDEF0, 32'h87654321, 0, 0));
    m_hi = result_hi; m_lo = result_lo;

    // Flush together with start in IDLE.
    @(negedge clk);
    op = MUL; rn = 32'd4; rs = 32'd4; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_idle_busy", {63'b0, busy}, 64'b0);
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("flush_start_idle_no_done", 64'(ndone), 64'd0);

    // Randomized operations against the model.
    for (int n = 0; n < 24; n++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      do_op(ro, ra, rb, $urandom, $urandom, $sformatf("rand%0d_op%0d", n, ro));
    end

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    op = UMULL; rn = 32'hFFFF0000; rs = 32'hF0000001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, result_hi, result_lo}, 66'b0);
    @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {63'b0, busy}, 64'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
